// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the EX-stage iterative multiply/divide unit:
// operation codes and controller states.
package ex_muldiv_unit_pkg;

   localparam logic [1:0] exe_multu_op = 2'b00;
   localparam logic [1:0] exe_mult_op  = 2'b01;
   localparam logic [1:0] exe_divu_op  = 2'b10;
   localparam logic [1:0] exe_div_op   = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit: shift-add multiply, restoring divide,
// one step per cycle, result committed to HI/LO on the DONE cycle unless annulled.
module ex_muldiv_unit
   import ex_muldiv_unit_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic             annul,
   output logic             stall_req,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   state_t                 state_reg, state_next;
   logic [CNT_W-1:0]       cnt_reg;
   logic [2*WIDTH-1:0]     acc_reg;
   logic [WIDTH-1:0]       opnd_reg;
   logic [1:0]             op_reg;
   logic                   sign1_reg, sign2_reg;
   logic [WIDTH-1:0]       res_hi_reg, res_lo_reg;
   logic [WIDTH-1:0]       hi_reg, lo_reg;

   logic                   accept, last_iter, sign1_in, sign2_in;
   logic [WIDTH:0]         mul_sum, rem_sh;
   logic                   div_ge;
   logic [WIDTH-1:0]       rem_new;
   logic [2*WIDTH-1:0]     mul_step, div_step, acc_step, prod;
   logic [WIDTH-1:0]       quot, rem, fin_hi, fin_lo;

   assign accept    = (state_reg == IDLE) && start && !annul;
   assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));
   assign sign1_in  = op[0] & src1[WIDTH-1];
   assign sign2_in  = op[0] & src2[WIDTH-1];

   // One iteration of each algorithm; acc holds {upper, lower} halves.
   always_comb begin
      mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
      mul_step = {mul_sum, acc_reg[WIDTH-1:1]};
      rem_sh   = acc_reg[2*WIDTH-1:WIDTH-1];
      div_ge   = (rem_sh >= {1'b0, opnd_reg});
      rem_new  = div_ge ? WIDTH'(rem_sh - {1'b0, opnd_reg}) : rem_sh[WIDTH-1:0];
      div_step = {rem_new, acc_reg[WIDTH-2:0], div_ge};
      acc_step = op_reg[1] ? div_step : mul_step;

      prod = (sign1_reg ^ sign2_reg) ? (~mul_step + 1'b1) : mul_step;
      quot = abs_val(div_step[WIDTH-1:0], sign1_reg ^ sign2_reg);
      rem  = abs_val(div_step[2*WIDTH-1:WIDTH], sign1_reg);
      fin_hi = op_reg[1] ? rem  : prod[2*WIDTH-1:WIDTH];
      fin_lo = op_reg[1] ? quot : prod[WIDTH-1:0];
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (accept) state_next = (op[1] && src2 == '0) ? DONE : BUSY;
         BUSY: begin
            if (annul)          state_next = IDLE;
            else if (last_iter) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         acc_reg    <= '0;
         opnd_reg   <= '0;
         op_reg     <= exe_multu_op;
         sign1_reg  <= 1'b0;
         sign2_reg  <= 1'b0;
         res_hi_reg <= '0;
         res_lo_reg <= '0;
         hi_reg     <= '0;
         lo_reg     <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: if (accept) begin
               op_reg    <= op;
               sign1_reg <= sign1_in;
               sign2_reg <= sign2_in;
               cnt_reg   <= '0;
               if (op[1]) begin
                  acc_reg  <= {{WIDTH{1'b0}}, abs_val(src1, sign1_in)};
                  opnd_reg <= abs_val(src2, sign2_in);
               end else begin
                  acc_reg  <= {{WIDTH{1'b0}}, abs_val(src2, sign2_in)};
                  opnd_reg <= abs_val(src1, sign1_in);
               end
               // Divide by zero skips iteration; dividend is reported unmodified.
               if (op[1] && src2 == '0) begin
                  res_hi_reg <= src1;
                  res_lo_reg <= '1;
               end
            end
            BUSY: begin
               acc_reg <= acc_step;
               cnt_reg <= cnt_reg + 1'b1;
               if (last_iter) begin
                  res_hi_reg <= fin_hi;
                  res_lo_reg <= fin_lo;
               end
            end
            DONE: if (!annul) begin
               hi_reg <= res_hi_reg;
               lo_reg <= res_lo_reg;
            end
            default: ;
         endcase
      end
   end

   // The result is presented during DONE itself so an annul can still suppress it.
   assign done      = (state_reg == DONE) && !annul;
   assign hi        = done ? res_hi_reg : hi_reg;
   assign lo        = done ? res_lo_reg : lo_reg;
   assign stall_req = accept || (state_reg == BUSY);

endmodule
